// File: rtl/etapa_busqueda.sv
// etapa_busqueda: instruction-fetch stage.
// Holds the program counter, requests instruction words over a req/ack
// handshake, registers the returned word and hands it to decode with a valid
// flag. Supports branch/jump redirection and flags misaligned targets and
// memory timeouts with a sticky error.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   habilitar_i           fetch enable
//   salto_i               redirect request (1-cycle pulse)
//   destino_salto_i[31:0] redirect target
//   mem_req_o, mem_dir_o  instruction-memory request and byte address
//   mem_ack_i, mem_dato_i memory response, data valid with ack
//   instruccion_o, pc_o   fetched word and its address
//   valida_o              instruccion_o/pc_o valid
//   consumida_i           decode accepted the instruction
//   error_o               sticky fault flag
//
// state    | meaning
// ---------+--------------------------------------------------------------
// INACTIVO | idle, no request outstanding
// SOLICITA | request in flight (first cycle after a redirect: request low)
// ENTREGA  | word held for decode until consumed
// ERROR    | misaligned target or timeout; only reset leaves
module etapa_busqueda #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          MAX_ESPERA = 16,
    parameter logic [31:0] INSTR_NOP  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        habilitar_i,
    input  logic        salto_i,
    input  logic [31:0] destino_salto_i,
    output logic        mem_req_o,
    output logic [31:0] mem_dir_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_dato_i,
    output logic [31:0] instruccion_o,
    output logic [31:0] pc_o,
    output logic        valida_o,
    input  logic        consumida_i,
    output logic        error_o
);

    localparam int CW = (MAX_ESPERA > 2) ? $clog2(MAX_ESPERA) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_ESPERA - 1);

    typedef enum logic [1:0] {INACTIVO, SOLICITA, ENTREGA, ERROR} estado_t;

    estado_t        estado, estado_d;
    logic [31:0]    pc, pc_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic           req_d, val_d, err_d;
    logic [31:0]    instr_d, pc_o_d;

    assign mem_dir_o = pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) estado <= INACTIVO;
        else       estado <= estado_d;
    end

    always_comb begin
        estado_d = estado;
        pc_d     = pc;
        cnt_d    = cnt;
        req_d    = mem_req_o;
        val_d    = valida_o;
        err_d    = error_o;
        instr_d  = instruccion_o;
        pc_o_d   = pc_o;

        if (estado == ERROR) begin
            req_d   = 1'b0;
            val_d   = 1'b0;
            err_d   = 1'b1;
            instr_d = INSTR_NOP;
        end else if (salto_i) begin
            val_d   = 1'b0;
            req_d   = 1'b0;
            instr_d = INSTR_NOP;
            cnt_d   = '0;
            if (destino_salto_i[1:0] != 2'b00) begin
                estado_d = ERROR;
                err_d    = 1'b1;
            end else begin
                pc_d     = destino_salto_i;
                estado_d = habilitar_i ? SOLICITA : INACTIVO;
            end
        end else begin
            case (estado)
                INACTIVO: begin
                    if (habilitar_i) begin
                        estado_d = SOLICITA;
                        req_d    = 1'b1;
                        cnt_d    = '0;
                    end
                end
                SOLICITA: begin
                    if (!mem_req_o) begin
                        // Bubble after a redirect: raise the request to the new pc.
                        req_d = 1'b1;
                    end else if (mem_ack_i) begin
                        // Ack beats a timeout on the same edge.
                        instr_d  = mem_dato_i;
                        pc_o_d   = pc;
                        val_d    = 1'b1;
                        req_d    = 1'b0;
                        cnt_d    = '0;
                        estado_d = ENTREGA;
                    end else if (cnt == CNT_MAX) begin
                        req_d    = 1'b0;
                        err_d    = 1'b1;
                        estado_d = ERROR;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                ENTREGA: begin
                    if (consumida_i) begin
                        val_d   = 1'b0;
                        instr_d = INSTR_NOP;
                        pc_d    = pc + 32'd4;
                        if (habilitar_i) begin
                            estado_d = SOLICITA;
                            req_d    = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            estado_d = INACTIVO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc            <= PC_RESET;
            cnt           <= '0;
            mem_req_o     <= 1'b0;
            valida_o      <= 1'b0;
            error_o       <= 1'b0;
            instruccion_o <= INSTR_NOP;
            pc_o          <= PC_RESET;
        end else begin
            pc            <= pc_d;
            cnt           <= cnt_d;
            mem_req_o     <= req_d;
            valida_o      <= val_d;
            error_o       <= err_d;
            instruccion_o <= instr_d;
            pc_o          <= pc_o_d;
        end
    end

endmodule

// File: tb/tb_etapa_busqueda.sv
// Directed bench for etapa_busqueda. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point. The instruction memory
// is a synchronous zero-wait model: it samples mem_req_o on an edge and
// answers with mem_ack_i during the following cycle.
module tb_etapa_busqueda;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        habilitar_i = 1'b0;
    logic        salto_i = 1'b0;
    logic [31:0] destino_salto_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_dir_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_dato_i = '0;
    logic [31:0] instruccion_o;
    logic [31:0] pc_o;
    logic        valida_o;
    logic        consumida_i = 1'b0;
    logic        error_o;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    etapa_busqueda dut (
        .clk_i(clk_i), .rst_i(rst_i), .habilitar_i(habilitar_i),
        .salto_i(salto_i), .destino_salto_i(destino_salto_i),
        .mem_req_o(mem_req_o), .mem_dir_o(mem_dir_o),
        .mem_ack_i(mem_ack_i), .mem_dato_i(mem_dato_i),
        .instruccion_o(instruccion_o), .pc_o(pc_o), .valida_o(valida_o),
        .consumida_i(consumida_i), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0050_0093;
            32'h0000_0004: rom = 32'hFFF0_0113;
            32'h0000_0008: rom = 32'h00A0_0193;
            32'h0000_0100: rom = 32'h0000_0513;
            32'hFFFF_FFFC: rom = 32'h0010_0073;
            default:       rom = {16'hBAD0, a[15:0]};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One clock with the memory model answering.
    task automatic mem_cycle();
        logic req_b, ack_b;
        req_b = mem_req_o;
        ack_b = mem_ack_i;
        tick();
        mem_ack_i  = req_b && !ack_b && mem_req_o;
        mem_dato_i = mem_ack_i ? rom(mem_dir_o) : 32'h0;
    endtask

    // Runs the memory model until valida_o rises; returns the cycle count.
    task automatic wait_valida(output int n);
        n = 0;
        do begin
            mem_cycle();
            n++;
        end while (!valida_o && n < 12);
        vectors++;
        if (valida_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_valida: valida_o=%b after %0d cycles, required 1", valida_o, n);
        end
    endtask

    task automatic apply_reset();
        habilitar_i = 0; salto_i = 0; destino_salto_i = '0;
        mem_ack_i = 0; mem_dato_i = '0; consumida_i = 0;
        rst_i = 1;
        tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        #3;
        rst_i = 1;
        #1;
        vectors++;
        if ({mem_req_o, valida_o, error_o, pc_o, instruccion_o, mem_dir_o} !==
            {1'b0, 1'b0, 1'b0, 32'h0, NOP, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_async: req=%b val=%b err=%b pc=%h ins=%h dir=%h, required 0 0 0 0 %h 0",
                     mem_req_o, valida_o, error_o, pc_o, instruccion_o, mem_dir_o, NOP);
        end
        tick();
        rst_i = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({mem_req_o, valida_o, pc_o, instruccion_o} !== {1'b0, 1'b0, 32'h0, NOP}) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: req=%b val=%b pc=%h ins=%h, required 0 0 0 %h",
                         i, mem_req_o, valida_o, pc_o, instruccion_o, NOP);
            end
        end
    endtask

    task automatic test_sequential();
        int n;
        apply_reset();
        habilitar_i = 1; consumida_i = 1;
        for (int k = 0; k < 3; k++) begin
            wait_valida(n);
            vectors++;
            if (instruccion_o !== rom(32'(4 * k)) || pc_o !== 32'(4 * k) || n != 3) begin
                miscompares++;
                $display("FAIL seq_fetch[%0d]: ins=%h pc=%h gap=%0d, required %h %h 3",
                         k, instruccion_o, pc_o, n, rom(32'(4 * k)), 32'(4 * k));
            end
        end
        habilitar_i = 0;
        mem_cycle();
        vectors++;
        if (mem_req_o !== 1'b0 || valida_o !== 1'b0 || mem_dir_o !== 32'hC || instruccion_o !== NOP) begin
            miscompares++;
            $display("FAIL seq_stop: req=%b val=%b dir=%h ins=%h, required 0 0 0000000c %h",
                     mem_req_o, valida_o, mem_dir_o, instruccion_o, NOP);
        end
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        habilitar_i = 1; consumida_i = 0;
        wait_valida(n);
        for (int i = 0; i < 4; i++) begin
            mem_cycle();
            vectors++;
            if (valida_o !== 1'b1 || instruccion_o !== 32'h0050_0093 || pc_o !== 32'h0 || mem_req_o !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: val=%b ins=%h pc=%h req=%b, required 1 00500093 0 0",
                         i, valida_o, instruccion_o, pc_o, mem_req_o);
            end
        end
        consumida_i = 1;
        mem_cycle();
        consumida_i = 0;
        vectors++;
        if (mem_req_o !== 1'b1 || mem_dir_o !== 32'h4 || valida_o !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_release: req=%b dir=%h val=%b, required 1 00000004 0",
                     mem_req_o, mem_dir_o, valida_o);
        end
    endtask

    task automatic test_redirect_ack();
        int n;
        apply_reset();
        habilitar_i = 1; consumida_i = 1;
        wait_valida(n);
        wait_valida(n);
        mem_cycle();   // consume 0x4, request 0x8
        mem_cycle();   // memory acks during this cycle
        vectors++;
        if (mem_req_o !== 1'b1 || mem_ack_i !== 1'b1 || mem_dir_o !== 32'h8) begin
            miscompares++;
            $display("FAIL redirect_setup: req=%b ack=%b dir=%h, required 1 1 00000008",
                     mem_req_o, mem_ack_i, mem_dir_o);
        end
        salto_i = 1; destino_salto_i = 32'h100;
        mem_cycle();
        salto_i = 0;
        vectors++;
        if (mem_req_o !== 1'b0 || valida_o !== 1'b0 || mem_dir_o !== 32'h100 || instruccion_o !== NOP) begin
            miscompares++;
            $display("FAIL redirect_drop: req=%b val=%b dir=%h ins=%h, required 0 0 00000100 %h",
                     mem_req_o, valida_o, mem_dir_o, instruccion_o, NOP);
        end
        mem_cycle();
        vectors++;
        if (mem_req_o !== 1'b1 || valida_o !== 1'b0 || mem_dir_o !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_reissue: req=%b val=%b dir=%h, required 1 0 00000100",
                     mem_req_o, valida_o, mem_dir_o);
        end
        wait_valida(n);
        vectors++;
        if (instruccion_o !== 32'h0000_0513 || pc_o !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_word: ins=%h pc=%h, required 00000513 00000100", instruccion_o, pc_o);
        end
    endtask

    task automatic test_misaligned();
        apply_reset();
        habilitar_i = 1;
        tick();
        salto_i = 1; destino_salto_i = 32'h102;
        tick();
        salto_i = 0;
        vectors++;
        if (error_o !== 1'b1 || mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned: err=%b req=%b, required 1 0", error_o, mem_req_o);
        end
        salto_i = 1; destino_salto_i = 32'h200; mem_ack_i = 1; consumida_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (error_o !== 1'b1 || mem_req_o !== 1'b0 || valida_o !== 1'b0) begin
                miscompares++;
                $display("FAIL error_sticky[%0d]: err=%b req=%b val=%b, required 1 0 0",
                         i, error_o, mem_req_o, valida_o);
            end
        end
        apply_reset();
        vectors++;
        if (error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL error_clear: err=%b, required 0", error_o);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        habilitar_i = 1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        vectors++;
        if (error_o !== 1'b0 || mem_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: err=%b req=%b after 15 waits, required 0 1", error_o, mem_req_o);
        end
        tick();
        vectors++;
        if (error_o !== 1'b1 || mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: err=%b req=%b after 16 waits, required 1 0", error_o, mem_req_o);
        end
    endtask

    // Ack lands on waiting cycle number waits+1 (15th, and the 16th which
    // coincides with the timeout edge).
    task automatic test_late_ack(input int waits);
        apply_reset();
        habilitar_i = 1;
        tick();
        for (int i = 0; i < waits; i++) tick();
        mem_ack_i = 1; mem_dato_i = 32'h1234_5677;
        tick();
        mem_ack_i = 0;
        vectors++;
        if (valida_o !== 1'b1 || error_o !== 1'b0 || instruccion_o !== 32'h1234_5677) begin
            miscompares++;
            $display("FAIL late_ack[%0d]: val=%b err=%b ins=%h, required 1 0 12345677",
                     waits + 1, valida_o, error_o, instruccion_o);
        end
    endtask

    task automatic test_wrap();
        int n;
        apply_reset();
        habilitar_i = 1; consumida_i = 0;
        salto_i = 1; destino_salto_i = 32'hFFFF_FFFC;
        mem_cycle();
        salto_i = 0;
        wait_valida(n);
        vectors++;
        if (instruccion_o !== 32'h0010_0073 || pc_o !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_word: ins=%h pc=%h, required 00100073 fffffffc", instruccion_o, pc_o);
        end
        consumida_i = 1;
        mem_cycle();
        vectors++;
        if (mem_dir_o !== 32'h0 || mem_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_pc: dir=%h req=%b, required 00000000 1", mem_dir_o, mem_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_ack();
        test_misaligned();
        test_timeout();
        test_late_ack(14);
        test_late_ack(15);
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
